// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory access stage.
// FSM state encoding and writeback field widths.
package mem_access_unit_pkg;

  localparam int WB_W = 2;
  localparam int RD_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_access_fsm.sv
// Sequencer for one data-memory transfer.
// req is registered so reset drops it at once.
module mem_access_fsm
  import mem_access_unit_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   mem_op,
  input  logic   dmem_ack,
  input  logic   misaligned,
  output state_t state,
  output logic   stall,
  output logic   req
);

  // Hold upstream while an op is accepted or in flight
  assign stall = ((state == IDLE) && mem_op) ||
                 (state == ACCESS);

  // State and request register; ack only matters in ACCESS
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      req   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_op) begin
            if (misaligned) begin
              state <= DONE;
            end else begin
              state <= ACCESS;
              req   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            state <= DONE;
            req   <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access stage: branch resolve, data-memory handshake, writeback regs.
// Optional MEM_ACCESS_MISALIGN_CHECK_EN enables the 8-byte alignment trap.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Branch,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic              comp,
  input  logic [WB_W-1:0]   WB,
  input  logic [ADDR_W-1:0] Adder_Result,
  input  logic [ADDR_W-1:0] ALU_Result,
  input  logic [DATA_W-1:0] Forward_B_Mux_Result,
  input  logic [RD_W-1:0]   rd,
  output logic              PCSrc,
  output logic [ADDR_W-1:0] branch_target,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic [WB_W-1:0]   WB_Out,
  output logic [DATA_W-1:0] read_data_out,
  output logic [ADDR_W-1:0] alu_result_out,
  output logic [RD_W-1:0]   rd_out,
  output logic              misalign
);

  logic              mem_op;
  logic              misaligned;
  state_t            state;
  logic [WB_W-1:0]   wb_q;
  logic [RD_W-1:0]   rd_q;
  logic [DATA_W-1:0] rdata_q;

  // Read+write together counts as a store
  assign mem_op = MemRead | MemWrite;

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
  assign misaligned = |ALU_Result[2:0];
`else
  assign misaligned = 1'b0;
`endif

  assign PCSrc         = Branch & comp & ~stall;
  assign branch_target = Adder_Result;

  mem_access_fsm u_fsm (
    .clk        (clk),
    .reset      (reset),
    .mem_op     (mem_op),
    .dmem_ack   (dmem_ack),
    .misaligned (misaligned),
    .state      (state),
    .stall      (stall),
    .req        (dmem_req)
  );

  // Latch the op, capture load data, and update writeback regs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      wb_q           <= '0;
      rd_q           <= '0;
      rdata_q        <= '0;
      wb_valid       <= 1'b0;
      WB_Out         <= '0;
      read_data_out  <= '0;
      alu_result_out <= '0;
      rd_out         <= '0;
    end else begin
      wb_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mem_op) begin
            dmem_addr  <= ALU_Result;
            dmem_wdata <= Forward_B_Mux_Result;
            dmem_we    <= MemWrite;
            wb_q       <= WB;
            rd_q       <= rd;
          end else begin
            wb_valid       <= 1'b1;
            WB_Out         <= WB;
            alu_result_out <= ALU_Result;
            rd_out         <= rd;
          end
        end
        ACCESS: begin
          if (dmem_ack && !dmem_we) begin
            rdata_q <= dmem_rdata;
          end
        end
        DONE: begin
          wb_valid       <= 1'b1;
          WB_Out         <= misalign ? '0 : wb_q;
          alu_result_out <= dmem_addr;
          rd_out         <= rd_q;
          read_data_out  <= rdata_q;
        end
        default: begin
          wb_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
  // Flag is high only for the DONE cycle of a trapped op
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign <= 1'b0;
    end else begin
      misalign <= (state == IDLE) && mem_op && misaligned;
    end
  end
`else
  assign misalign = 1'b0;
`endif

endmodule
